de_stage_pipe_reg: RTL and testbench
====================================

Name: de_stage_pipe_reg

Overview:
- Parametrised decode→execute pipeline register for the 16-bit core.
- Carries a packed control word, two source operands and register specifiers.
- Adds a valid/ready handshake with a 2-entry skid buffer, so the stage can stall without a combinational ready path back into decode.
- Adds a synchronous flush for branch squash, and gates control fields to zero whenever the stage holds a bubble.

Parameters:
- DATA_W, 16, width of srcA/srcB operands
- REG_AW, 4, width of rs1/rs2/rd register specifiers
- CTRL_W, 9, width of packed control word; field layout from de_pipe_pkg

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  squash all held entries at next edge
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept; registered
- ctrl_in  in  CTRL_W  packed control (post NOP-mux)
- srcA_in  in  DATA_W  operand A
- srcB_in  in  DATA_W  operand B
- rs1_in  in  REG_AW  source reg 1
- rs2_in  in  REG_AW  source reg 2
- rd_in  in  REG_AW  destination reg
- out_valid  out  1  execute-side entry valid
- out_ready  in  1  execute consumes entry
- wre_out  out  1  register-file write enable
- mem_we_out  out  1  data-memory write enable
- wb_sel_out  out  2  writeback mux select
- alu_op_out  out  4  ALU operation
- load_out  out  1  instruction is a load
- srcA_out, srcB_out  out  DATA_W  operands
- rs1_out, rs2_out, rd_out  out  REG_AW  register specifiers
- load_use_stall  out  1  hazard request to decode (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-high. Asserting reset clears to 0, immediately and independent of clk:
  - main_valid, skid_valid and all stored fields
  - every output, with in_ready=1
  - Deassertion takes effect at the next clk edge; mid-operation reset discards all entries.
- Storage: main entry (drives outputs) plus skid entry. FSM derived from {main_valid, skid_valid}:
  - EMPTY: accept → ONE.
  - ONE, no consume: accept → FULL, captured into skid.
  - ONE, consume: accept → stay ONE with new main; no accept → EMPTY.
  - FULL, consume: skid→main, go to ONE. FULL, no consume: hold.
- Handshake:
  - accept = in_valid && in_ready; consume = out_valid && out_ready.
  - in_ready = !skid_valid, registered, so decode sees no combinational path from out_ready.
- Latency: 1 cycle from accept to out_valid when EMPTY; throughput 1/cycle with out_ready held high.
- Ordering is strictly FIFO; skid is never bypassed by a newer entry.
- Flush:
  - At the next edge, flush clears main_valid and skid_valid → EMPTY.
  - Overrides a simultaneous accept (input dropped) and a simultaneous consume; in_ready=1 the following cycle.
- Bubble gating: when out_valid=0, wre_out, mem_we_out and load_out are forced to 0, and alu_op_out/wb_sel_out are forced to 0. Data and specifier outputs keep their last values.
- Control word layout, fixed in the package: [8] wre, [7] load, [6] mem_we, [5:4] wb_sel, [3:0] alu_op. CTRL_W < 9 is illegal; an elaboration assertion catches it.

Optional Feature:
- Macro: DE_STAGE_LOAD_USE_DETECT_EN.
- Defined:
  - load_use_stall = out_valid && load_out && rd_out != 0 && in_valid && (rd_out == rs1_in || rd_out == rs2_in). Purely combinational.
  - Decode must hold its instruction and drive in_valid with the NOP-mux bubble until the stall clears.
  - A simultaneous flush has no effect on the stall value that cycle.
- Undefined: load_use_stall tied to 0; hazard detection lives elsewhere.

Decomposition:
- Package de_pipe_pkg holds:
  - ctrl field index constants (CTRL_WRE_BIT, CTRL_LOAD_BIT, CTRL_MEMWE_BIT, CTRL_WBSEL_LSB, CTRL_ALUOP_LSB) and CTRL_W_MIN=9
  - typedef de_entry_t: struct of ctrl, srcA, srcB, rs1, rs2, rd
- One sub-module, pipe_skid_buf, generic over payload width. It owns the valid/ready FSM and the two entries. The top does packing, bubble gating and hazard compare.

Test Plan:
- Reset: assert reset mid-stream with FULL state → out_valid=0 and all outputs 0 without a clk edge; in_ready=1 after deassert.
- Pass-through: out_ready=1, send ctrl=9'h1A5, srcA=16'h1234 → next cycle out_valid=1, wre_out=1, load_out=1, mem_we_out=0, wb_sel_out=2'b10, alu_op_out=4'h5, srcA_out=16'h1234.
- Backpressure: out_ready=0, send A then B → after B, in_ready=0. Release out_ready → A, then B, on consecutive cycles; in_ready returns 1.
- Flush in FULL with concurrent in_valid=1 → next cycle out_valid=0, wre_out=0, mem_we_out=0; dropped input never appears.
- Load-use (macro defined): main holds load with rd=3; in_valid with rs2_in=3 → load_use_stall=1. With rd=0 → 0. Macro undefined → always 0.
- Throughput: 8 back-to-back instructions with out_ready=1 → 8 consecutive out_valid cycles, in order, no drops.

Source files
------------

// File: rtl/de_pipe_pkg.sv
// Shared definitions for the decode->execute pipeline register.
// Control word layout: [8] wre, [7] load, [6] mem_we, [5:4] wb_sel, [3:0] alu_op.
package de_pipe_pkg;

   localparam int unsigned CTRL_W_MIN     = 9;
   localparam int unsigned CTRL_WRE_BIT   = 8;
   localparam int unsigned CTRL_LOAD_BIT  = 7;
   localparam int unsigned CTRL_MEMWE_BIT = 6;
   localparam int unsigned CTRL_WBSEL_LSB = 4;
   localparam int unsigned CTRL_ALUOP_LSB = 0;

   localparam int unsigned DE_DATA_W = 16;
   localparam int unsigned DE_REG_AW = 4;

   // One decode->execute entry at the core's native widths.
   typedef struct packed {
      logic [CTRL_W_MIN-1:0] ctrl;
      logic [DE_DATA_W-1:0]  srcA;
      logic [DE_DATA_W-1:0]  srcB;
      logic [DE_REG_AW-1:0]  rs1;
      logic [DE_REG_AW-1:0]  rs2;
      logic [DE_REG_AW-1:0]  rd;
   } de_entry_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer: a main entry that drives the output and a
// skid entry that absorbs one extra beat, so in_ready_o comes from a flop.
// State is {main_valid, skid_valid}; flush empties both at the next edge.
module pipe_skid_buf #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b10;
   localparam logic [1:0] ST_FULL  = 2'b11;

   logic         main_valid_q, main_valid_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] main_data_q,  main_data_d;
   logic [W-1:0] skid_data_q,  skid_data_d;
   logic         in_ready_q;
   logic         accept, consume;
   logic [1:0]   state;

   assign state   = {main_valid_q, skid_valid_q};
   assign accept  = in_valid_i && in_ready_q;
   assign consume = main_valid_q && out_ready_i;

   // Next-state for the two entries; skid always drains into main before new data.
   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_data_d  = main_data_q;
      skid_data_d  = skid_data_q;
      case (state)
         ST_EMPTY: begin
            if (accept) begin
               main_valid_d = 1'b1;
               main_data_d  = in_data_i;
            end
         end
         ST_ONE: begin
            if (consume) begin
               if (accept) main_data_d  = in_data_i;
               else        main_valid_d = 1'b0;
            end else if (accept) begin
               skid_valid_d = 1'b1;
               skid_data_d  = in_data_i;
            end
         end
         ST_FULL: begin
            if (consume) begin
               main_data_d  = skid_data_q;
               skid_valid_d = 1'b0;
            end
         end
         default: begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
         end
      endcase
      if (flush_i) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end
   end

   // Entry registers and the registered ready, all cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_data_q  <= '0;
         in_ready_q   <= 1'b1;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_data_q  <= main_data_d;
         skid_data_q  <= skid_data_d;
         in_ready_q   <= !skid_valid_d;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = main_valid_q;
   assign out_data_o  = main_data_q;

endmodule

// File: rtl/de_stage_pipe_reg.sv
// Decode->execute pipeline register with valid/ready handshake, 2-entry skid
// buffer, synchronous flush and bubble gating of control fields.
// Optional: DE_STAGE_LOAD_USE_DETECT_EN enables the load-use hazard compare.
module de_stage_pipe_reg
   import de_pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 4,
   parameter int unsigned CTRL_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [DATA_W-1:0] srcA_in,
   input  logic [DATA_W-1:0] srcB_in,
   input  logic [REG_AW-1:0] rs1_in,
   input  logic [REG_AW-1:0] rs2_in,
   input  logic [REG_AW-1:0] rd_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              wre_out,
   output logic              mem_we_out,
   output logic [1:0]        wb_sel_out,
   output logic [3:0]        alu_op_out,
   output logic              load_out,
   output logic [DATA_W-1:0] srcA_out,
   output logic [DATA_W-1:0] srcB_out,
   output logic [REG_AW-1:0] rs1_out,
   output logic [REG_AW-1:0] rs2_out,
   output logic [REG_AW-1:0] rd_out,
   output logic              load_use_stall
);

   localparam int unsigned PAY_W = CTRL_W + 2 * DATA_W + 3 * REG_AW;

   generate
      if (CTRL_W < CTRL_W_MIN) begin : g_ctrl_w_check
         $error("de_stage_pipe_reg: CTRL_W must be at least 9");
      end
   endgenerate

   logic [PAY_W-1:0]  in_pay, out_pay;
   logic [CTRL_W-1:0] main_ctrl;

   assign in_pay = {ctrl_in, srcA_in, srcB_in, rs1_in, rs2_in, rd_in};

   pipe_skid_buf #(
      .W (PAY_W)
   ) u_skid (
      .clk         (clk),
      .rst         (reset),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_pay),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_pay)
   );

   assign {main_ctrl, srcA_out, srcB_out, rs1_out, rs2_out, rd_out} = out_pay;

   // Control fields are forced to zero whenever the stage holds a bubble.
   always_comb begin
      wre_out    = 1'b0;
      load_out   = 1'b0;
      mem_we_out = 1'b0;
      wb_sel_out = '0;
      alu_op_out = '0;
      if (out_valid) begin
         wre_out    = main_ctrl[CTRL_WRE_BIT];
         load_out   = main_ctrl[CTRL_LOAD_BIT];
         mem_we_out = main_ctrl[CTRL_MEMWE_BIT];
         wb_sel_out = main_ctrl[CTRL_WBSEL_LSB +: 2];
         alu_op_out = main_ctrl[CTRL_ALUOP_LSB +: 4];
      end
   end

`ifdef DE_STAGE_LOAD_USE_DETECT_EN
   // Load in execute whose destination feeds the instruction now in decode.
   assign load_use_stall = out_valid && load_out && (rd_out != '0) && in_valid &&
                           ((rd_out == rs1_in) || (rd_out == rs2_in));
`else
   assign load_use_stall = 1'b0;
`endif

endmodule

// File: tb/tb_de_stage_pipe_reg.sv
// Directed, table-driven bench for de_stage_pipe_reg.
module tb_de_stage_pipe_reg;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [8:0]  ctrl_in;
   logic [15:0] srcA_in, srcB_in;
   logic [3:0]  rs1_in, rs2_in, rd_in;
   logic        wre_out, mem_we_out, load_out, load_use_stall;
   logic [1:0]  wb_sel_out;
   logic [3:0]  alu_op_out;
   logic [15:0] srcA_out, srcB_out;
   logic [3:0]  rs1_out, rs2_out, rd_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   de_stage_pipe_reg #(.DATA_W(16), .REG_AW(4), .CTRL_W(9)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .ctrl_in(ctrl_in), .srcA_in(srcA_in), .srcB_in(srcB_in),
      .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .wre_out(wre_out), .mem_we_out(mem_we_out), .wb_sel_out(wb_sel_out),
      .alu_op_out(alu_op_out), .load_out(load_out),
      .srcA_out(srcA_out), .srcB_out(srcB_out),
      .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
      .load_use_stall(load_use_stall)
   );

   typedef struct {
      logic [8:0]  ctrl;
      logic [15:0] a, b;
      logic [3:0]  r1, r2, rd;
      logic        e_wre, e_load, e_mem;
      logic [1:0]  e_wb;
      logic [3:0]  e_alu;
   } vec_t;

   vec_t vecs[8];

`ifdef DE_STAGE_LOAD_USE_DETECT_EN
   localparam logic LU_EN = 1'b1;
`else
   localparam logic LU_EN = 1'b0;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      ctrl_in = v.ctrl; srcA_in = v.a; srcB_in = v.b;
      rs1_in = v.r1; rs2_in = v.r2; rd_in = v.rd;
   endtask

   task automatic chk_entry(input string nm, input vec_t v);
      chk({nm, ".valid"}, 32'(out_valid), 32'd1);
      chk({nm, ".wre"},   32'(wre_out),    32'(v.e_wre));
      chk({nm, ".load"},  32'(load_out),   32'(v.e_load));
      chk({nm, ".memwe"}, 32'(mem_we_out), 32'(v.e_mem));
      chk({nm, ".wbsel"}, 32'(wb_sel_out), 32'(v.e_wb));
      chk({nm, ".aluop"}, 32'(alu_op_out), 32'(v.e_alu));
      chk({nm, ".srcA"},  32'(srcA_out),   32'(v.a));
      chk({nm, ".srcB"},  32'(srcB_out),   32'(v.b));
      chk({nm, ".rs1"},   32'(rs1_out),    32'(v.r1));
      chk({nm, ".rs2"},   32'(rs2_out),    32'(v.r2));
      chk({nm, ".rd"},    32'(rd_out),     32'(v.rd));
   endtask

   task automatic chk_bubble(input string nm);
      chk({nm, ".valid"}, 32'(out_valid),  32'd0);
      chk({nm, ".wre"},   32'(wre_out),    32'd0);
      chk({nm, ".load"},  32'(load_out),   32'd0);
      chk({nm, ".memwe"}, 32'(mem_we_out), 32'd0);
      chk({nm, ".wbsel"}, 32'(wb_sel_out), 32'd0);
      chk({nm, ".aluop"}, 32'(alu_op_out), 32'd0);
   endtask

   vec_t va, vb, vc;

   initial begin
      //          ctrl     a         b         r1 r2 rd  wre ld mem wb     alu
      vecs[0] = '{9'h1A5, 16'h1234, 16'h0001, 1, 2, 3,  1, 1, 0, 2'b10, 4'h5};
      vecs[1] = '{9'h000, 16'hFFFF, 16'h0000, 0, 0, 0,  0, 0, 0, 2'b00, 4'h0};
      vecs[2] = '{9'h040, 16'hA002, 16'hB002, 4, 5, 6,  0, 0, 1, 2'b00, 4'h0};
      vecs[3] = '{9'h13F, 16'hA003, 16'hB003, 7, 8, 9,  1, 0, 0, 2'b11, 4'hF};
      vecs[4] = '{9'h0B2, 16'hA004, 16'hB004, 10,11,12, 0, 1, 0, 2'b11, 4'h2};
      vecs[5] = '{9'h1FF, 16'hA005, 16'hB005, 13,14,15, 1, 1, 1, 2'b11, 4'hF};
      vecs[6] = '{9'h0D7, 16'hA006, 16'hB006, 15,1, 2,  0, 1, 1, 2'b01, 4'h7};
      vecs[7] = '{9'h129, 16'hA007, 16'hB007, 3, 4, 5,  1, 0, 0, 2'b10, 4'h9};

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      ctrl_in = '0; srcA_in = '0; srcB_in = '0; rs1_in = '0; rs2_in = '0; rd_in = '0;
      #1;
      chk_bubble("rst");
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.srcA", 32'(srcA_out), 32'd0);
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("post_rst.in_ready", 32'(in_ready), 32'd1);
      chk_bubble("post_rst");

      // Back-to-back stream with out_ready high: one output per cycle, in order.
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i]);
         in_valid = 1'b1;
         tick();
         chk_entry($sformatf("stream%0d", i), vecs[i]);
         chk($sformatf("stream%0d.in_ready", i), 32'(in_ready), 32'd1);
      end
      in_valid = 1'b0;
      tick();
      chk_bubble("drain");
      chk("drain.srcA_hold", 32'(srcA_out), 32'hA007);
      chk("drain.rd_hold",   32'(rd_out),   32'd5);

      // Backpressure: A then B fill the stage, C is refused while full.
      va = vecs[0]; va.a = 16'h0AAA;
      vb = vecs[3]; vb.a = 16'h0BBB;
      vc = vecs[5]; vc.a = 16'h0CCC;
      out_ready = 1'b0;
      drive(va); in_valid = 1'b1;
      tick();
      chk_entry("bp.A1", va);
      chk("bp.A1.in_ready", 32'(in_ready), 32'd1);
      drive(vb);
      tick();
      chk_entry("bp.A2", va);
      chk("bp.full.in_ready", 32'(in_ready), 32'd0);
      drive(vc);
      tick();
      chk_entry("bp.A3", va);
      chk("bp.hold.in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk_entry("bp.B", vb);
      chk("bp.B.in_ready", 32'(in_ready), 32'd1);
      tick();
      chk_bubble("bp.end");
      chk("bp.end.srcA", 32'(srcA_out), 32'h0BBB);

      // Flush while full with a concurrent input and consume: all dropped.
      out_ready = 1'b0;
      drive(vecs[5]); in_valid = 1'b1;
      tick();
      drive(vecs[6]);
      tick();
      chk("fl.full.in_ready", 32'(in_ready), 32'd0);
      drive(vecs[7]); flush = 1'b1; out_ready = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk_bubble("fl.full");
      chk("fl.full.in_ready1", 32'(in_ready), 32'd1);
      tick();
      chk_bubble("fl.full.after");

      // Flush in ONE with an acceptable input: the input is dropped.
      drive(vecs[3]); in_valid = 1'b1;
      tick();
      chk_entry("fl.one.pre", vecs[3]);
      drive(vecs[4]); flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk_bubble("fl.one");
      chk("fl.one.in_ready", 32'(in_ready), 32'd1);
      tick();
      chk_bubble("fl.one.after");

      // Load-use: load with rd=3 held in execute.
      out_ready = 1'b0;
      va = '{9'h180, 16'h1111, 16'h2222, 1, 2, 3, 1, 1, 0, 2'b00, 4'h0};
      drive(va); in_valid = 1'b1;
      tick();
      chk_entry("lu.load", va);
      rs1_in = 4'd5; rs2_in = 4'd3; #1;
      chk("lu.rs2_hit", 32'(load_use_stall), 32'(LU_EN));
      rs1_in = 4'd3; rs2_in = 4'd9; #1;
      chk("lu.rs1_hit", 32'(load_use_stall), 32'(LU_EN));
      flush = 1'b1; #1;
      chk("lu.hit_flush", 32'(load_use_stall), 32'(LU_EN));
      flush = 1'b0;
      rs1_in = 4'd7; rs2_in = 4'd7; #1;
      chk("lu.miss", 32'(load_use_stall), 32'd0);
      rs1_in = 4'd3; in_valid = 1'b0; #1;
      chk("lu.no_valid", 32'(load_use_stall), 32'd0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      vb = '{9'h180, 16'h3333, 16'h4444, 0, 0, 0, 1, 1, 0, 2'b00, 4'h0};
      drive(vb); in_valid = 1'b1;
      tick();
      chk_entry("lu.rd0", vb);
      rs1_in = 4'd0; rs2_in = 4'd0; #1;
      chk("lu.rd0_stall", 32'(load_use_stall), 32'd0);

      // Asynchronous reset mid-stream while full.
      rd_in = 4'd6; srcA_in = 16'h5555;
      tick();
      chk("ar.full.in_ready", 32'(in_ready), 32'd0);
      #2 reset = 1'b1;
      #1;
      chk_bubble("ar");
      chk("ar.in_ready", 32'(in_ready), 32'd1);
      chk("ar.srcA", 32'(srcA_out), 32'd0);
      chk("ar.rd",   32'(rd_out),   32'd0);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk_bubble("ar.after");
      chk("ar.after.in_ready", 32'(in_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
